// File: rtl/apb_spi_master_if.sv
// APB slave bus plus SPI pins of apb_spi_master, bundled for port connection.
// The slave modport faces the SPI master block; master faces the bus/pads.
interface apb_spi_master_if #(
  parameter int PADDR_WIDTH = 8,
  parameter int PDATA_WIDTH = 32,
  parameter int NUM_CS      = 4
);
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [PADDR_WIDTH-1:0] PADDR;
  logic [PDATA_WIDTH-1:0] PWDATA;
  logic [PDATA_WIDTH-1:0] PRDATA;
  logic                   PREADY;
  logic                   PSLVERR;
  logic                   SCLK;
  logic                   MOSI;
  logic                   MISO;
  logic [NUM_CS-1:0]      CS_n;
  logic                   irq;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, MISO,
    output PRDATA, PREADY, PSLVERR, SCLK, MOSI, CS_n, irq
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, MISO,
    input  PRDATA, PREADY, PSLVERR, SCLK, MOSI, CS_n, irq
  );
endinterface

// File: rtl/apb_spi_master.sv
// APB-programmable SPI master: configurable width, mode, bit order,
// SCLK divider and chip select, single PCLK domain.
module apb_spi_master #(
  parameter int DATA_WIDTH  = 8,
  parameter int PADDR_WIDTH = 8,
  parameter int PDATA_WIDTH = 32,
  parameter int NUM_CS      = 4,
  parameter int DIV_WIDTH   = 8
) (
  input logic PCLK,
  input logic reset,
  apb_spi_master_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, SETUP, SHIFT, HOLD
  } state_e;

  localparam int EW = 7;
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_WIDTH);

  state_e                 state_q, state_d;
  logic [7:0]             ctrl_q, ctrl_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [DIV_WIDTH-1:0]   div_a_q, div_a_d;
  logic                   cpha_a_q, cpha_a_d;
  logic                   lsb_a_q, lsb_a_d;
  logic [2:0]             cs_a_q, cs_a_d;
  logic [DIV_WIDTH-1:0]   tmr_q, tmr_d;
  logic [EW-1:0]          ev_q, ev_d;
  logic                   sclk_q, sclk_d;
  logic [DATA_WIDTH-1:0]  sh_q, sh_d;
  logic [DATA_WIDTH-1:0]  rx_q, rx_d;
  logic [DATA_WIDTH-1:0]  rxdata_q, rxdata_d;
  logic                   rxv_q, rxv_d;
  logic                   ovr_q, ovr_d;

  logic                   access, wr, rd, mapped, busy;
  logic                   cs_bad, abort, tick, complete;
  logic                   sample, shift, lead, err;
  logic [2:0]             idx;
  logic [EW-1:0]          ev_nx;
  logic [PDATA_WIDTH-1:0] prdata;
  logic                   unused_bits;

  assign access = bus.PSEL & bus.PENABLE;
  assign wr     = access & bus.PWRITE;
  assign rd     = access & ~bus.PWRITE;
  assign idx    = bus.PADDR[4:2];
  assign mapped = idx <= 3'd4;
  assign busy   = state_q != IDLE;
  assign cs_bad = {1'b0, bus.PWDATA[7:5]} >= 4'(NUM_CS);
  assign abort  = wr && idx == 3'd0 && !cs_bad
                  && busy && !bus.PWDATA[0];
  assign tick   = busy && !abort && tmr_q == div_a_q;
  assign ev_nx  = ev_q + 1'b1;
  assign lead   = ev_nx[0];
  assign unused_bits = ^{bus.PADDR, bus.PWDATA};

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    div_d    = div_q;
    div_a_d  = div_a_q;
    cpha_a_d = cpha_a_q;
    lsb_a_d  = lsb_a_q;
    cs_a_d   = cs_a_q;
    tmr_d    = tmr_q;
    ev_d     = ev_q;
    sclk_d   = sclk_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    rxdata_d = rxdata_q;
    rxv_d    = rxv_q;
    ovr_d    = ovr_q;
    complete = 1'b0;
    sample   = 1'b0;
    shift    = 1'b0;
    err      = access && !mapped;
    prdata   = '0;

    if (busy) tmr_d = tick ? '0 : tmr_q + 1'b1;

    // Event k: k<=2W is an SCLK edge, k=2W+1 ends HOLD.
    if (tick) begin
      ev_d = ev_nx;
      if (ev_nx > LAST) begin
        complete = 1'b1;
        state_d  = IDLE;
      end else begin
        sclk_d  = ~sclk_q;
        state_d = (ev_nx == LAST) ? HOLD : SHIFT;
        sample  = cpha_a_q ? !lead : lead;
        shift   = cpha_a_q ? (lead && ev_nx != 1)
                           : (!lead && ev_nx != LAST);
      end
    end

    if (sample) begin
      rx_d = lsb_a_q ? (rx_q >> 1) : (rx_q << 1);
      rx_d[lsb_a_q ? DATA_WIDTH-1 : 0] = bus.MISO;
    end
    if (shift) sh_d = lsb_a_q ? (sh_q >> 1) : (sh_q << 1);

    if (complete) rxdata_d = rx_q;
    if (rd && idx == 3'd3) rxv_d = 1'b0;
    if (complete) rxv_d = 1'b1;

    if (abort) begin
      state_d = IDLE;
      tmr_d   = '0;
      ev_d    = '0;
    end

    if (wr) begin
      case (idx)
        3'd0: begin
          if (cs_bad) err = 1'b1;
          else ctrl_d = bus.PWDATA[7:0];
        end
        3'd1: div_d = bus.PWDATA[DIV_WIDTH-1:0];
        3'd2: begin
          if (busy) begin
            err   = 1'b1;
            ovr_d = 1'b1;
          end else if (ctrl_q[0]) begin
            state_d  = SETUP;
            tmr_d    = '0;
            ev_d     = '0;
            sh_d     = bus.PWDATA[DATA_WIDTH-1:0];
            rx_d     = '0;
            sclk_d   = ctrl_q[1];
            cpha_a_d = ctrl_q[2];
            lsb_a_d  = ctrl_q[3];
            cs_a_d   = ctrl_q[7:5];
            div_a_d  = div_q;
          end
        end
        3'd4: if (bus.PWDATA[2]) ovr_d = 1'b0;
        default: ;
      endcase
    end

    if (rd) begin
      case (idx)
        3'd0: prdata = PDATA_WIDTH'(ctrl_q);
        3'd1: prdata = PDATA_WIDTH'(div_q);
        3'd3: prdata = PDATA_WIDTH'(rxdata_q);
        3'd4: prdata = PDATA_WIDTH'({ovr_q, rxv_q, busy});
        default: prdata = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      div_q    <= '0;
      div_a_q  <= '0;
      cpha_a_q <= 1'b0;
      lsb_a_q  <= 1'b0;
      cs_a_q   <= '0;
      tmr_q    <= '0;
      ev_q     <= '0;
      sclk_q   <= 1'b0;
      sh_q     <= '0;
      rx_q     <= '0;
      rxdata_q <= '0;
      rxv_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      div_a_q  <= div_a_d;
      cpha_a_q <= cpha_a_d;
      lsb_a_q  <= lsb_a_d;
      cs_a_q   <= cs_a_d;
      tmr_q    <= tmr_d;
      ev_q     <= ev_d;
      sclk_q   <= sclk_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      rxdata_q <= rxdata_d;
      rxv_q    <= rxv_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.PRDATA  = prdata;
  assign bus.PREADY  = access;
  assign bus.PSLVERR = access & err;
  assign bus.SCLK    = busy ? sclk_q : ctrl_q[1];
  assign bus.MOSI    = busy ? (lsb_a_q ? sh_q[0] : sh_q[DATA_WIDTH-1])
                            : 1'b0;
  assign bus.CS_n    = busy ? ~(NUM_CS'(1) << cs_a_q) : '1;
  assign bus.irq     = rxv_q & ctrl_q[4];
endmodule

// File: tb/tb_apb_spi_master.sv
// Directed bench for apb_spi_master with an RX scoreboard queue.
// MISO loops back from MOSI unless a pattern is being driven.
module tb_apb_spi_master;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int PW  = 32;
  localparam int NCS = 4;
  localparam int DVW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_spi_master_if #(
    .PADDR_WIDTH(AW), .PDATA_WIDTH(PW), .NUM_CS(NCS)
  ) bus ();

  apb_spi_master #(
    .DATA_WIDTH(DW), .PADDR_WIDTH(AW), .PDATA_WIDTH(PW),
    .NUM_CS(NCS), .DIV_WIDTH(DVW)
  ) dut (
    .PCLK(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] last_rx = '0;

  logic       pat_en = 1'b0;
  logic [7:0] pat = '0;
  int         pidx = 0;
  int         poff = 0;
  logic       miso_r = 1'b0;
  assign bus.MISO = pat_en ? miso_r : bus.MOSI;

  // Pattern mode drives the next bit on each SCLK falling edge.
  always @(negedge bus.SCLK) begin
    miso_r <= pat[3'(pidx - poff)];
    pidx   <= pidx + 1;
  end

  logic mon_en = 1'b0;
  logic mosi_seen[$];
  always @(posedge bus.SCLK)
    if (mon_en) mosi_seen.push_back(bus.MOSI);

  int cs_low = 0;
  logic [NCS-1:0] cs_seen = '1;
  always @(negedge clk)
    if (bus.CS_n != '1) begin
      cs_low  <= cs_low + 1;
      cs_seen <= bus.CS_n;
    end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic w, input logic [7:0] a,
                     input logic [31:0] d,
                     output logic [31:0] rdat, output logic err);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    bus.PWRITE = w; bus.PADDR = a; bus.PWDATA = d;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk);
    rdat = bus.PRDATA;
    err  = bus.PSLVERR;
    chk("pready", 32'(bus.PREADY), 32'd1);
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic exp_err, input string tag);
    logic [31:0] r;
    logic e;
    apb(1'b1, a, d, r, e);
    chk(tag, 32'(e), 32'(exp_err));
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp,
                    input string tag);
    logic [31:0] r;
    logic e;
    apb(1'b0, a, 32'h0, r, e);
    chk(tag, r, exp);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.CS_n != '1 && n < 5000);
    chk({tag, "_tmo"}, 32'(n < 5000), 32'd1);
  endtask

  task automatic rx_check(input string tag);
    logic [PW-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      rd(8'h0C, e, tag);
      last_rx = e;
    end
  endtask

  int base;
  logic [7:0] v;

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sclk", 32'(bus.SCLK), 32'd0);
    chk("rst_mosi", 32'(bus.MOSI), 32'd0);
    chk("rst_cs", 32'(bus.CS_n), 32'hF);
    chk("rst_prdata", bus.PRDATA, 32'd0);
    chk("rst_pready", 32'(bus.PREADY), 32'd0);
    chk("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    rst = 1'b0;
    rd(8'h00, 32'h0, "rst_ctrl");
    rd(8'h10, 32'h0, "rst_status");

    // Mode 0 loopback, DIV=1, MSB first, IE on.
    wr(8'h04, 32'h1, 1'b0, "t1_div");
    wr(8'h00, 32'h11, 1'b0, "t1_ctrl");
    mosi_seen.delete();
    mon_en = 1'b1;
    base = cs_low;
    wr(8'h08, 32'hA5, 1'b0, "t1_tx");
    exp_q.push_back(32'hA5);
    wait_done("t1");
    mon_en = 1'b0;
    chk("t1_cs_cycles", 32'(cs_low - base), 32'd34);
    chk("t1_cs_sel", 32'(cs_seen), 32'hE);
    chk("t1_mosi_n", 32'(mosi_seen.size()), 32'd8);
    v = 8'hA5;
    for (int i = 0; i < 8; i++)
      if (i < mosi_seen.size())
        chk($sformatf("t1_mosi%0d", i),
            32'(mosi_seen[i]), 32'(v[7-i]));
    chk("t1_irq", 32'(bus.irq), 32'd1);
    rd(8'h10, 32'h2, "t1_status");
    rx_check("t1_rx");
    @(negedge clk);
    chk("t1_irq_clr", 32'(bus.irq), 32'd0);
    rd(8'h10, 32'h0, "t1_status2");

    // Mode 3, LSB first, CS 2, MISO from pattern.
    wr(8'h00, 32'h4F, 1'b0, "t2_ctrl");
    @(negedge clk);
    chk("t2_sclk_idle", 32'(bus.SCLK), 32'd1);
    pat = 8'h4A;
    poff = pidx;
    pat_en = 1'b1;
    wr(8'h08, 32'h81, 1'b0, "t2_tx");
    exp_q.push_back(32'h4A);
    wait_done("t2");
    pat_en = 1'b0;
    chk("t2_cs_sel", 32'(cs_seen), 32'hB);
    chk("t2_sclk_end", 32'(bus.SCLK), 32'd1);
    rx_check("t2_rx");

    // Overrun while busy, then W1C.
    wr(8'h00, 32'h01, 1'b0, "t3_ctrl");
    wr(8'h08, 32'h96, 1'b0, "t3_tx");
    exp_q.push_back(32'h96);
    wr(8'h08, 32'h55, 1'b1, "t3_ovr_err");
    rd(8'h10, 32'h5, "t3_status");
    wait_done("t3");
    rx_check("t3_rx");
    rd(8'h10, 32'h4, "t3_ovr_kept");
    wr(8'h10, 32'h4, 1'b0, "t3_w1c");
    rd(8'h10, 32'h0, "t3_ovr_clr");

    // DIV=0: SCLK at PCLK/2.
    wr(8'h04, 32'h0, 1'b0, "t4_div");
    base = cs_low;
    wr(8'h08, 32'hC3, 1'b0, "t4_tx");
    exp_q.push_back(32'hC3);
    wait_done("t4");
    chk("t4_cs_cycles", 32'(cs_low - base), 32'd17);
    rx_check("t4_rx");

    // Abort mid-shift.
    wr(8'h04, 32'h1, 1'b0, "t5_div");
    wr(8'h08, 32'hFF, 1'b0, "t5_tx");
    repeat (10) @(posedge clk);
    wr(8'h00, 32'h00, 1'b0, "t5_abort");
    @(negedge clk);
    chk("t5_cs", 32'(bus.CS_n), 32'hF);
    chk("t5_sclk", 32'(bus.SCLK), 32'd0);
    rd(8'h10, 32'h0, "t5_status");
    rd(8'h0C, last_rx, "t5_rx_kept");

    // Error responses.
    rd(8'h14, 32'h0, "t6_unmapped_data");
    wr(8'h14, 32'h0, 1'b1, "t6_unmapped_err");
    wr(8'h00, 32'hA1, 1'b1, "t6_cs_bad");
    rd(8'h00, 32'h0, "t6_ctrl_kept");

    // Async reset mid-shift with CPOL=1.
    wr(8'h00, 32'h03, 1'b0, "t7_ctrl");
    wr(8'h08, 32'h5A, 1'b0, "t7_tx");
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t7_sclk", 32'(bus.SCLK), 32'd0);
    chk("t7_mosi", 32'(bus.MOSI), 32'd0);
    chk("t7_cs", 32'(bus.CS_n), 32'hF);
    chk("t7_irq", 32'(bus.irq), 32'd0);
    chk("t7_pready", 32'(bus.PREADY), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(8'h00, 32'h0, "t7_ctrl_rst");
    rd(8'h0C, 32'h0, "t7_rx_rst");
    wr(8'h04, 32'h1, 1'b0, "t7_div");
    wr(8'h00, 32'h01, 1'b0, "t7_ctrl2");
    base = cs_low;
    wr(8'h08, 32'h3C, 1'b0, "t7_tx2");
    exp_q.push_back(32'h3C);
    wait_done("t7");
    chk("t7_cs_cycles", 32'(cs_low - base), 32'd34);
    rx_check("t7_rx");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
